// File: rtl/cache_ctrl.sv
// Cache management unit for a 2-way, 32-set, 4-word-line data cache: hit/miss handling,
// dirty-victim write-back and word-by-word line refill over a req/ack memory bus.
module cache_ctrl #(
   parameter int ADDR_BITS  = 32,
   parameter int TAG_BITS   = 23,
   parameter int SET_NUM    = 32,
   parameter int LINE_WORDS = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cpu_req,
   input  logic                 cpu_we,
   input  logic [ADDR_BITS-1:0] cpu_addr,
   input  logic [2:0]           cpu_u_b_h_w,
   input  logic [31:0]          cpu_din,
   output logic [31:0]          cpu_dout,
   output logic                 cpu_stall,
   output logic [ADDR_BITS-1:0] cache_addr,
   output logic                 cache_load,
   output logic                 cache_edit,
   output logic                 cache_store,
   output logic                 cache_invalid,
   output logic [2:0]           cache_u_b_h_w,
   output logic [31:0]          cache_din,
   input  logic                 cache_hit,
   input  logic                 cache_valid,
   input  logic                 cache_dirty,
   input  logic [TAG_BITS-1:0]  cache_tag,
   input  logic [31:0]          cache_dout,
   output logic                 mem_cs,
   output logic                 mem_we,
   output logic [ADDR_BITS-1:0] mem_addr,
   output logic [31:0]          mem_dout,
   input  logic [31:0]          mem_din,
   input  logic                 mem_ack
);

   localparam int SET_BITS  = $clog2(SET_NUM);
   localparam int WORD_BITS = $clog2(LINE_WORDS);
   localparam int OFF       = WORD_BITS + 2;

   typedef enum logic [2:0] {INIT, IDLE, CHECK, WB_RD, WB_WR, FILL, REFILL} state_t;

   state_t                state_q, state_d;
   logic [SET_BITS-1:0]   set_cnt_q, set_cnt_d;
   logic [WORD_BITS-1:0]  word_cnt_q, word_cnt_d;
   logic [TAG_BITS-1:0]   victim_tag_q, victim_tag_d;
   logic [31:0]           wb_data_q, wb_data_d;
   logic                  wb_fresh_q, wb_fresh_d;
   logic [ADDR_BITS-1:0]  line_addr;

   assign line_addr     = {cpu_addr[ADDR_BITS-1:OFF], word_cnt_q, 2'b00};
   assign cpu_dout      = cache_dout;
   assign cache_u_b_h_w = cpu_u_b_h_w;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= INIT;
         set_cnt_q    <= '0;
         word_cnt_q   <= '0;
         victim_tag_q <= '0;
         wb_data_q    <= '0;
         wb_fresh_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         set_cnt_q    <= set_cnt_d;
         word_cnt_q   <= word_cnt_d;
         victim_tag_q <= victim_tag_d;
         wb_data_q    <= wb_data_d;
         wb_fresh_q   <= wb_fresh_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      set_cnt_d     = set_cnt_q;
      word_cnt_d    = word_cnt_q;
      victim_tag_d  = victim_tag_q;
      wb_data_d     = wb_data_q;
      wb_fresh_d    = 1'b0;
      cpu_stall     = cpu_req;
      cache_addr    = '0;
      cache_load    = 1'b0;
      cache_edit    = 1'b0;
      cache_store   = 1'b0;
      cache_invalid = 1'b0;
      cache_din     = cpu_din;
      mem_cs        = 1'b0;
      mem_we        = 1'b0;
      mem_addr      = '0;
      mem_dout      = '0;

      case (state_q)
         INIT: begin
            cache_invalid                = ~rst;
            cache_addr[OFF +: SET_BITS]  = set_cnt_q;
            set_cnt_d                    = set_cnt_q + SET_BITS'(1);
            if (set_cnt_q == SET_BITS'(SET_NUM - 1))
               state_d = IDLE;
         end
         IDLE: begin
            cache_addr = cpu_addr;
            cache_load = cpu_req & ~cpu_we;
            cache_edit = cpu_req & cpu_we;
            if (cpu_req)
               state_d = CHECK;
         end
         CHECK: begin
            cpu_stall = ~cache_hit;
            if (cache_hit) begin
               state_d = IDLE;
            end else begin
               word_cnt_d = '0;
               if (cache_valid && cache_dirty) begin
                  victim_tag_d = cache_tag;
                  state_d      = WB_RD;
               end else begin
                  state_d = FILL;
               end
            end
         end
         WB_RD: begin
            cache_addr = line_addr;
            wb_fresh_d = 1'b1;
            state_d    = WB_WR;
         end
         // First WB_WR cycle forwards the freshly read word; later cycles replay the held copy.
         WB_WR: begin
            cache_addr = line_addr;
            mem_cs     = 1'b1;
            mem_we     = 1'b1;
            mem_addr   = {victim_tag_q, cpu_addr[OFF+SET_BITS-1:OFF], word_cnt_q, 2'b00};
            mem_dout   = wb_fresh_q ? cache_dout : wb_data_q;
            wb_data_d  = mem_dout;
            if (mem_ack) begin
               if (word_cnt_q == '1) begin
                  word_cnt_d = '0;
                  state_d    = FILL;
               end else begin
                  word_cnt_d = word_cnt_q + WORD_BITS'(1);
                  state_d    = WB_RD;
               end
            end
         end
         FILL: begin
            cache_addr = line_addr;
            cache_din  = mem_din;
            mem_cs     = 1'b1;
            mem_addr   = line_addr;
            if (mem_ack) begin
               cache_store = 1'b1;
               if (word_cnt_q == '1)
                  state_d = REFILL;
               else
                  word_cnt_d = word_cnt_q + WORD_BITS'(1);
            end
         end
         REFILL: begin
            state_d = IDLE;
         end
         default: begin
            state_d = INIT;
         end
      endcase
   end

endmodule

// File: tb/tb_cache_ctrl.sv
// Self-checking bench for cache_ctrl: behavioural 2-way cache, ack-delayed memory,
// a golden byte-addressed memory and scoreboards for CPU data and memory transactions.
module tb_cache_ctrl;

   logic        clk, rst;
   logic        cpu_req, cpu_we;
   logic [31:0] cpu_addr, cpu_din, cpu_dout;
   logic [2:0]  cpu_u_b_h_w;
   logic        cpu_stall;
   logic [31:0] cache_addr, cache_din, cache_dout;
   logic        cache_load, cache_edit, cache_store, cache_invalid;
   logic [2:0]  cache_u_b_h_w;
   logic        cache_hit, cache_valid, cache_dirty;
   logic [22:0] cache_tag;
   logic        mem_cs, mem_we, mem_ack;
   logic [31:0] mem_addr, mem_dout, mem_din;

   localparam logic [2:0] SZ_B = 3'b000, SZ_H = 3'b001, SZ_W = 3'b010, SZ_BU = 3'b100;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [31:0] data;
   } txn_t;

   int total = 0;
   int bad   = 0;
   int ack_delay = 0;
   int unstable_cnt = 0;
   int store_cnt = 0;
   txn_t        mem_log[$];
   txn_t        mem_exp_q[$];
   logic [31:0] exp_q[$];
   logic [31:0] mem_arr[logic [31:0]];
   logic [31:0] ref_mem[logic [31:0]];

   cache_ctrl dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_u_b_h_w(cpu_u_b_h_w),
      .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_stall(cpu_stall),
      .cache_addr(cache_addr), .cache_load(cache_load), .cache_edit(cache_edit),
      .cache_store(cache_store), .cache_invalid(cache_invalid), .cache_u_b_h_w(cache_u_b_h_w),
      .cache_din(cache_din), .cache_hit(cache_hit), .cache_valid(cache_valid),
      .cache_dirty(cache_dirty), .cache_tag(cache_tag), .cache_dout(cache_dout),
      .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_dout(mem_dout),
      .mem_din(mem_din), .mem_ack(mem_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] def_word(input logic [31:0] a);
      return 32'h000000A0 + {28'b0, a[3:2], 2'b00} / 4;
   endfunction

   function automatic logic [31:0] ld_extract(input logic [31:0] w, input logic [2:0] ubhw,
                                              input logic [1:0] off);
      logic [31:0] sh;
      sh = w >> {off, 3'b000};
      case (ubhw[1:0])
         2'd0:    return ubhw[2] ? {24'b0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
         2'd1:    return ubhw[2] ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
         default: return w;
      endcase
   endfunction

   function automatic logic [31:0] st_merge(input logic [31:0] old, input logic [31:0] din,
                                            input logic [2:0] ubhw, input logic [1:0] off);
      logic [31:0] m;
      m = (ubhw[1:0] == 2'd0) ? 32'h000000FF : (ubhw[1:0] == 2'd1) ? 32'h0000FFFF : 32'hFFFFFFFF;
      m = m << {off, 3'b000};
      return (old & ~m) | ((din << {off, 3'b000}) & m);
   endfunction

   function automatic logic [31:0] ref_word(input logic [31:0] a);
      logic [31:0] w;
      w = {a[31:2], 2'b00};
      return ref_mem.exists(w) ? ref_mem[w] : def_word(w);
   endfunction

   // Behavioural cache: registered status/data, LRU victim, victim read when idle.
   logic [4:0]  m_set;
   logic [1:0]  m_word;
   logic [22:0] m_tag;
   logic        m_hit0, m_hit1, m_vict;
   bit          c_valid[2][32];
   bit          c_dirty[2][32];
   bit [22:0]   c_tag[2][32];
   bit [31:0]   c_data[2][32][4];
   bit          c_lru[32];

   always_comb begin
      m_set  = cache_addr[8:4];
      m_word = cache_addr[3:2];
      m_tag  = cache_addr[31:9];
      m_hit0 = c_valid[0][m_set] && (c_tag[0][m_set] == m_tag);
      m_hit1 = c_valid[1][m_set] && (c_tag[1][m_set] == m_tag);
      m_vict = c_lru[m_set];
   end

   always @(posedge clk) begin
      cache_hit <= 1'b0;
      if (cache_invalid) begin
         c_valid[0][m_set] <= 1'b0;
         c_valid[1][m_set] <= 1'b0;
         c_dirty[0][m_set] <= 1'b0;
         c_dirty[1][m_set] <= 1'b0;
         c_lru[m_set]      <= 1'b0;
      end else if (cache_load || cache_edit) begin
         if (m_hit0 || m_hit1) begin
            cache_hit    <= 1'b1;
            c_lru[m_set] <= m_hit0;
            if (cache_load) begin
               cache_dout <= ld_extract(c_data[m_hit1][m_set][m_word], cache_u_b_h_w, cache_addr[1:0]);
            end else begin
               c_data[m_hit1][m_set][m_word] <= st_merge(c_data[m_hit1][m_set][m_word], cache_din,
                                                         cache_u_b_h_w, cache_addr[1:0]);
               c_dirty[m_hit1][m_set] <= 1'b1;
            end
         end else begin
            cache_valid <= c_valid[m_vict][m_set];
            cache_dirty <= c_dirty[m_vict][m_set];
            cache_tag   <= c_tag[m_vict][m_set];
         end
      end else if (cache_store) begin
         c_data[m_vict][m_set][m_word] <= cache_din;
         c_tag[m_vict][m_set]          <= m_tag;
         c_valid[m_vict][m_set]        <= 1'b1;
         c_dirty[m_vict][m_set]        <= 1'b0;
      end else begin
         cache_dout <= c_data[m_vict][m_set][m_word];
      end
   end

   always @(negedge clk) if (cache_store) store_cnt <= store_cnt + 1;

   // Memory: acks after ack_delay wait cycles, logs each completed transfer, watches stability.
   initial begin
      int          wait_cnt;
      logic [31:0] req_addr, req_dout;
      logic        req_we;
      txn_t        t;
      wait_cnt = 0;
      mem_ack  = 1'b0;
      mem_din  = 32'hBAD0BAD0;
      forever begin
         @(posedge clk);
         #2;
         mem_ack = 1'b0;
         mem_din = 32'hBAD0BAD0;
         if (rst || !mem_cs) begin
            wait_cnt = 0;
         end else begin
            if (wait_cnt == 0) begin
               req_addr = mem_addr;
               req_we   = mem_we;
               req_dout = mem_dout;
            end else if (mem_addr !== req_addr || mem_we !== req_we || (req_we && mem_dout !== req_dout)) begin
               unstable_cnt++;
            end
            if (wait_cnt == ack_delay) begin
               mem_ack = 1'b1;
               t.addr  = mem_addr;
               t.we    = mem_we;
               if (mem_we) begin
                  mem_arr[mem_addr] = mem_dout;
                  t.data = mem_dout;
               end else begin
                  mem_din = mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : def_word(mem_addr);
                  t.data  = mem_din;
               end
               mem_log.push_back(t);
               wait_cnt = 0;
            end else begin
               wait_cnt++;
            end
         end
      end
   end

   task automatic push_line(input logic [31:0] base, input logic we);
      txn_t t;
      for (int i = 0; i < 4; i++) begin
         t.addr = base + 32'(4 * i);
         t.we   = we;
         t.data = we ? ref_word(t.addr) : 32'h0;
         mem_exp_q.push_back(t);
      end
   endtask

   task automatic do_access(input logic we, input logic [31:0] addr, input logic [2:0] ubhw,
                            input logic [31:0] din, input bit hold, output logic [31:0] rdata,
                            output int stalls, output bit done, output logic stall_after);
      logic [31:0] w;
      @(posedge clk);
      #2;
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_u_b_h_w = ubhw; cpu_din = din;
      w = {addr[31:2], 2'b00};
      if (we) ref_mem[w] = st_merge(ref_word(w), din, ubhw, addr[1:0]);
      else    exp_q.push_back(ld_extract(ref_word(w), ubhw, addr[1:0]));
      stalls = 0; done = 0; rdata = 'x; stall_after = 1'bx;
      for (int i = 0; i < 400 && !done; i++) begin
         @(negedge clk);
         if (cpu_stall) stalls++;
         else begin
            done  = 1;
            rdata = cpu_dout;
         end
      end
      if (hold && done) begin
         @(negedge clk);
         stall_after = cpu_stall;
      end
      cpu_req = 1'b0;
   endtask

   task automatic test_reset();
      int inv_cnt, order_bad;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++;
      if (cache_invalid !== 1'b0 || mem_cs !== 1'b0 || cache_addr !== 32'h0 || cpu_stall !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset_outputs got inv=%b cs=%b addr=%h stall=%b need 0/0/0/0",
                  cache_invalid, mem_cs, cache_addr, cpu_stall);
      end
      @(posedge clk);
      #2;
      rst = 1'b0;
      inv_cnt = 0; order_bad = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (cache_invalid) begin
            if (cache_addr !== (32'(inv_cnt) << 4)) order_bad++;
            inv_cnt++;
         end
         if (i == 5) begin
            cpu_req = 1'b1;
            #1;
            total++;
            if (cpu_stall !== 1'b1) begin
               bad++;
               $display("[TB] FAIL init_stall got=%b need=1", cpu_stall);
            end
            cpu_req = 1'b0;
         end
      end
      total++;
      if (inv_cnt != 32) begin
         bad++;
         $display("[TB] FAIL sweep_len got=%0d need=32", inv_cnt);
      end
      total++;
      if (order_bad != 0) begin
         bad++;
         $display("[TB] FAIL sweep_order got=%0d bad addresses need=0", order_bad);
      end
      total++;
      if (cpu_stall !== 1'b0) begin
         bad++;
         $display("[TB] FAIL idle_stall_noreq got=%b need=0", cpu_stall);
      end
      cpu_req = 1'b1;
      #1;
      total++;
      if (cpu_stall !== 1'b1) begin
         bad++;
         $display("[TB] FAIL idle_stall_req got=%b need=1", cpu_stall);
      end
      cpu_req = 1'b0;
   endtask

   task automatic test_cold_load();
      logic [31:0] rd, ex;
      int          st, s0;
      bit          ok;
      logic        sa;
      txn_t        e, o;
      mem_log.delete();
      ack_delay = 2;
      s0 = store_cnt;
      push_line(32'h100, 1'b0);
      do_access(1'b0, 32'h104, SZ_W, 32'h0, 1'b0, rd, st, ok, sa);
      ex = exp_q.pop_front();
      total++;
      if (!ok || rd !== ex || rd !== 32'h000000A1) begin
         bad++;
         $display("[TB] FAIL cold_load_data got=%h done=%0d need=%h", rd, ok, ex);
      end
      total++;
      if (st != 16) begin
         bad++;
         $display("[TB] FAIL cold_load_stalls got=%0d need=16", st);
      end
      total++;
      if (store_cnt - s0 != 4) begin
         bad++;
         $display("[TB] FAIL cold_store_pulses got=%0d need=4", store_cnt - s0);
      end
      while (mem_exp_q.size() > 0) begin
         e = mem_exp_q.pop_front();
         total++;
         if (mem_log.size() == 0) begin
            bad++;
            $display("[TB] FAIL cold_memtxn got=none need addr=%h we=%b", e.addr, e.we);
         end else begin
            o = mem_log.pop_front();
            if (o.addr !== e.addr || o.we !== e.we) begin
               bad++;
               $display("[TB] FAIL cold_memtxn got addr=%h we=%b need addr=%h we=%b", o.addr, o.we, e.addr, e.we);
            end
         end
      end
   endtask

   task automatic test_hit();
      logic [31:0] rd, ex;
      int          st;
      bit          ok;
      logic        sa;
      mem_log.delete();
      do_access(1'b0, 32'h108, SZ_W, 32'h0, 1'b1, rd, st, ok, sa);
      ex = exp_q.pop_front();
      total++;
      if (!ok || rd !== ex || rd !== 32'h000000A2) begin
         bad++;
         $display("[TB] FAIL hit_data got=%h need=%h", rd, ex);
      end
      total++;
      if (st != 1) begin
         bad++;
         $display("[TB] FAIL hit_stalls got=%0d need=1", st);
      end
      total++;
      if (sa !== 1'b1) begin
         bad++;
         $display("[TB] FAIL hit_stall_low_once got=%b need=1", sa);
      end
      total++;
      if (mem_log.size() != 0) begin
         bad++;
         $display("[TB] FAIL hit_no_mem got=%0d txns need=0", mem_log.size());
      end
   endtask

   task automatic test_writeback();
      logic [31:0] rd, ex;
      int          st;
      bit          ok;
      logic        sa;
      txn_t        e, o;
      mem_log.delete();
      ack_delay = 1;
      do_access(1'b1, 32'h104, SZ_W, 32'hDEADBEEF, 1'b0, rd, st, ok, sa);
      push_line(32'h2100, 1'b0);
      do_access(1'b0, 32'h2104, SZ_W, 32'h0, 1'b0, rd, st, ok, sa);
      ex = exp_q.pop_front();
      total++;
      if (!ok || rd !== ex) begin
         bad++;
         $display("[TB] FAIL wb_miss2_data got=%h need=%h", rd, ex);
      end
      push_line(32'h100, 1'b1);
      push_line(32'h4100, 1'b0);
      do_access(1'b0, 32'h4104, SZ_W, 32'h0, 1'b0, rd, st, ok, sa);
      ex = exp_q.pop_front();
      total++;
      if (!ok || rd !== ex) begin
         bad++;
         $display("[TB] FAIL wb_load_data got=%h need=%h", rd, ex);
      end
      while (mem_exp_q.size() > 0) begin
         e = mem_exp_q.pop_front();
         total++;
         if (mem_log.size() == 0) begin
            bad++;
            $display("[TB] FAIL wb_memtxn got=none need addr=%h we=%b", e.addr, e.we);
         end else begin
            o = mem_log.pop_front();
            if (o.addr !== e.addr || o.we !== e.we || (e.we && o.data !== e.data)) begin
               bad++;
               $display("[TB] FAIL wb_memtxn got %h/%b/%h need %h/%b/%h",
                        o.addr, o.we, o.data, e.addr, e.we, e.data);
            end
         end
      end
      total++;
      if (mem_arr[32'h104] !== 32'hDEADBEEF) begin
         bad++;
         $display("[TB] FAIL wb_mem_word got=%h need=deadbeef", mem_arr[32'h104]);
      end
   endtask

   task automatic test_byte_access();
      logic [31:0] rd, ex;
      int          st;
      bit          ok;
      logic        sa;
      mem_log.delete();
      ack_delay = 0;
      do_access(1'b1, 32'h107, SZ_B, 32'h00000080, 1'b0, rd, st, ok, sa);
      total++;
      if (!ok || mem_log.size() != 4) begin
         bad++;
         $display("[TB] FAIL sb_refill got=%0d txns done=%0d need=4", mem_log.size(), ok);
      end
      do_access(1'b0, 32'h107, SZ_B, 32'h0, 1'b0, rd, st, ok, sa);
      ex = exp_q.pop_front();
      total++;
      if (!ok || rd !== ex || rd !== 32'hFFFFFF80) begin
         bad++;
         $display("[TB] FAIL lb_data got=%h need=ffffff80", rd);
      end
      do_access(1'b0, 32'h107, SZ_BU, 32'h0, 1'b0, rd, st, ok, sa);
      ex = exp_q.pop_front();
      total++;
      if (!ok || rd !== ex || rd !== 32'h00000080) begin
         bad++;
         $display("[TB] FAIL lbu_data got=%h need=00000080", rd);
      end
      do_access(1'b0, 32'h106, SZ_H, 32'h0, 1'b0, rd, st, ok, sa);
      ex = exp_q.pop_front();
      total++;
      if (!ok || rd !== ex || rd !== 32'hFFFF80AD) begin
         bad++;
         $display("[TB] FAIL lh_data got=%h need=%h", rd, ex);
      end
   endtask

   task automatic test_ack_delay();
      logic [31:0] rd, ex;
      int          st, u0;
      bit          ok;
      logic        sa;
      txn_t        e, o;
      mem_log.delete();
      ack_delay = 5;
      u0 = unstable_cnt;
      do_access(1'b1, 32'h4108, SZ_W, 32'h12345678, 1'b0, rd, st, ok, sa);
      push_line(32'h100, 1'b1);
      push_line(32'h6100, 1'b0);
      do_access(1'b0, 32'h6104, SZ_W, 32'h0, 1'b0, rd, st, ok, sa);
      ex = exp_q.pop_front();
      total++;
      if (!ok || rd !== ex) begin
         bad++;
         $display("[TB] FAIL slow_load_data got=%h need=%h", rd, ex);
      end
      total++;
      if (unstable_cnt != u0) begin
         bad++;
         $display("[TB] FAIL slow_bus_stable got=%0d changes need=0", unstable_cnt - u0);
      end
      while (mem_exp_q.size() > 0) begin
         e = mem_exp_q.pop_front();
         total++;
         if (mem_log.size() == 0) begin
            bad++;
            $display("[TB] FAIL slow_memtxn got=none need addr=%h we=%b", e.addr, e.we);
         end else begin
            o = mem_log.pop_front();
            if (o.addr !== e.addr || o.we !== e.we || (e.we && o.data !== e.data)) begin
               bad++;
               $display("[TB] FAIL slow_memtxn got %h/%b/%h need %h/%b/%h",
                        o.addr, o.we, o.data, e.addr, e.we, e.data);
            end
         end
      end
   endtask

   task automatic test_reset_mid_fill();
      logic [31:0] rd, ex;
      int          st;
      bit          ok, seen;
      logic        sa;
      txn_t        e, o;
      mem_log.delete();
      ack_delay = 1;
      @(posedge clk);
      #2;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h1234; cpu_u_b_h_w = SZ_W;
      seen = 0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         if (mem_log.size() >= 2) seen = 1;
      end
      total++;
      if (!seen) begin
         bad++;
         $display("[TB] FAIL midfill_progress got=%0d words need=2", mem_log.size());
      end
      @(posedge clk);
      #3;
      total++;
      if (mem_cs !== 1'b1) begin
         bad++;
         $display("[TB] FAIL midfill_busy got cs=%b need=1", mem_cs);
      end
      rst = 1'b1;
      #1;
      total++;
      if (mem_cs !== 1'b0 || cache_store !== 1'b0) begin
         bad++;
         $display("[TB] FAIL midfill_async got cs=%b store=%b need 0/0", mem_cs, cache_store);
      end
      cpu_req = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b0;
      repeat (40) @(negedge clk);
      mem_log.delete();
      push_line(32'h1230, 1'b0);
      do_access(1'b0, 32'h1234, SZ_W, 32'h0, 1'b0, rd, st, ok, sa);
      ex = exp_q.pop_front();
      total++;
      if (!ok || rd !== ex || rd !== 32'h000000A1) begin
         bad++;
         $display("[TB] FAIL midfill_reload_data got=%h need=%h", rd, ex);
      end
      while (mem_exp_q.size() > 0) begin
         e = mem_exp_q.pop_front();
         total++;
         if (mem_log.size() == 0) begin
            bad++;
            $display("[TB] FAIL midfill_memtxn got=none need addr=%h", e.addr);
         end else begin
            o = mem_log.pop_front();
            if (o.addr !== e.addr || o.we !== e.we) begin
               bad++;
               $display("[TB] FAIL midfill_memtxn got %h/%b need %h/%b", o.addr, o.we, e.addr, e.we);
            end
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_u_b_h_w = SZ_W; cpu_din = 32'h0;
      test_reset();
      test_cold_load();
      test_hit();
      test_writeback();
      test_byte_access();
      test_ack_delay();
      test_reset_mid_fill();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
